multi_ff_bank: RTL and testbench
================================

MULTI_FF_BANK -- requirements
Module: multi_ff_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning number of independent flip-flop channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning illegal-event counter width (2..16).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port en  in  1  update enable; 0 holds all channel state.
REQ-006 SHALL have port mode  in  2  requested mode: 00 RS, 01 JK, 10 D, 11 T.
REQ-007 SHALL have port S  in  WIDTH  per-channel set / J / D / T input.
REQ-008 SHALL have port R  in  WIDTH  per-channel reset / K input; ignored in D and T modes.
REQ-009 SHALL have port clr_err  in  1  clears sticky error flags and counter.
REQ-010 SHALL have port Q  out  WIDTH  channel state.
REQ-011 SHALL have port nQ  out  WIDTH  always the bitwise inverse of Q.
REQ-012 SHALL have port act_mode  out  2  mode currently applied.
REQ-013 SHALL have port busy  out  1  high while a mode switch is in progress.
REQ-014 SHALL have port err  out  WIDTH  sticky per-channel illegal-input flag.
REQ-015 SHALL have port err_cnt  out  CNT_W  saturating count of cycles with any illegal input.

Function
REQ-016 Controller SHALL have states RUN and SWITCH.
REQ-017 In RUN with en=1, each channel SHALL update Q per act_mode: RS 00 hold, 01 clear, 10 set, 11 illegal; JK (J=S, K=R) 00 hold, 01 clear, 10 set, 11 toggle; D Q<=S; T Q<=Q^S.
REQ-018 Illegal RS input (R=S=1, act_mode RS, en=1, RUN) SHALL hold that channel's Q and set its err bit the same edge.
REQ-019 err_cnt SHALL increment by exactly 1 per edge on which at least one channel is illegal, regardless of how many, and saturate at all-ones.
REQ-020 In RUN, mode != act_mode SHALL move to SWITCH on the next edge, with busy=1 and Q not updated on that edge.
REQ-021 SWITCH SHALL last exactly one cycle: Q held, act_mode<=mode sampled that edge, return to RUN with busy=0.
REQ-022 A mode change during SWITCH SHALL be taken as the new act_mode; any further difference starts another SWITCH.
REQ-023 en=0 SHALL hold Q and suppress illegal detection; mode switching SHALL proceed regardless of en.
REQ-024 clr_err=1 SHALL zero err and err_cnt on the next edge; if an illegal input occurs the same edge, err SHALL take only the new illegal bits and err_cnt SHALL become 1.
REQ-025 No illegal detection SHALL occur in SWITCH or in JK, D or T modes.
REQ-026 nQ SHALL be combinationally ~Q with no cycle offset.

Reset
REQ-027 nrst=0 at an edge SHALL set Q=0, nQ all-ones, act_mode=00, state RUN, busy=0, err=0, err_cnt=0, overriding all other inputs.
REQ-028 Reset asserted during SWITCH SHALL abort the switch; act_mode SHALL be 00 after reset.
REQ-029 First edge after nrst rises SHALL behave as normal RUN; mode != 00 there SHALL start a SWITCH.

Structure
REQ-030 Package multi_ff_pkg SHALL hold mode encodings (MODE_RS, MODE_JK, MODE_D, MODE_T) and controller state encodings.
REQ-031 Sub-module ff_cell SHALL implement one channel (next-state logic, Q register, illegal flag); multi_ff_bank SHALL instantiate WIDTH copies plus controller and counter.

Verification
REQ-032 Reset: nrst=0 with S=R=all-ones -> Q=0x00, nQ=0xFF, err=0, err_cnt=0, act_mode=00.
REQ-033 RS: S=0x0F,R=0 then S=0,R=0x03 then S=R=0x80 -> Q=0x0F, 0x0C, 0x0C; err=0x80; err_cnt=1.
REQ-034 Switch: mode=01 in RUN -> busy=1 one cycle, Q held, act_mode=01 next; then S=R=0xFF -> Q toggles each edge, no err.
REQ-035 Saturation: CNT_W=2, four illegal RS edges -> err_cnt 1,2,3,3.
REQ-036 clr_err same edge as illegal on channel 2 -> err=0x04, err_cnt=1.
REQ-037 Reset mid-SWITCH (mode 00->11, nrst=0 during busy) -> act_mode=00, busy=0, Q=0.

Source files
------------

// File: rtl/multi_ff_pkg.sv
// Shared encodings for the multi-mode flip-flop bank.
package multi_ff_pkg;

    typedef enum logic [1:0] {
        MODE_RS = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } state_e;

endpackage : multi_ff_pkg

// File: rtl/ff_cell.sv
// One flip-flop channel: mode-dependent next-state logic, Q register and
// sticky illegal-input flag.
// Ports: clk, nrst (sync, active-low), upd (channel may update this edge),
//        mode (applied mode), s/r (set-J-D-T / reset-K), clr_err,
//        q (state), err (sticky illegal flag), illegal_c (illegal this cycle).
module ff_cell
    import multi_ff_pkg::*;
(
    input  logic  clk,
    input  logic  nrst,
    input  logic  upd,
    input  mode_e mode,
    input  logic  s,
    input  logic  r,
    input  logic  clr_err,
    output logic  q,
    output logic  err,
    output logic  illegal_c
);

    logic q_next;

    // Next-state selection; R=S=1 in RS mode holds Q and flags illegal.
    always_comb begin
        q_next    = q;
        illegal_c = 1'b0;
        if (upd) begin
            case (mode)
                MODE_RS: begin
                    case ({s, r})
                        2'b01:   q_next = 1'b0;
                        2'b10:   q_next = 1'b1;
                        2'b11:   illegal_c = 1'b1;
                        default: q_next = q;
                    endcase
                end
                MODE_JK: begin
                    case ({s, r})
                        2'b01:   q_next = 1'b0;
                        2'b10:   q_next = 1'b1;
                        2'b11:   q_next = ~q;
                        default: q_next = q;
                    endcase
                end
                MODE_D:  q_next = s;
                MODE_T:  q_next = q ^ s;
                default: q_next = q;
            endcase
        end
    end

    // State and sticky flag; a clear keeps only this edge's illegal bit.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            q   <= 1'b0;
            err <= 1'b0;
        end else begin
            q   <= q_next;
            err <= clr_err ? illegal_c : (err | illegal_c);
        end
    end

endmodule : ff_cell

// File: rtl/multi_ff_bank.sv
// Bank of WIDTH flip-flop channels sharing a selectable mode (RS/JK/D/T).
// A mode change passes through a one-cycle SWITCH state during which Q holds.
// Ports: clk, nrst (sync, active-low), en, mode, S, R, clr_err,
//        Q, nQ (combinational ~Q), act_mode, busy, err, err_cnt.
module multi_ff_bank
    import multi_ff_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic             clr_err,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ,
    output logic [1:0]       act_mode,
    output logic             busy,
    output logic [WIDTH-1:0] err,
    output logic [CNT_W-1:0] err_cnt
);

    state_e           state;
    mode_e            act_mode_q;
    mode_e            mode_req;
    logic             upd_c;
    logic [WIDTH-1:0] illegal_c;
    logic             any_illegal_c;

    assign mode_req = mode_e'(mode);
    assign act_mode = act_mode_q;
    assign nQ       = ~Q;

    // Channels update only in RUN with a settled mode; a pending change freezes Q.
    assign upd_c         = en && (state == ST_RUN) && (mode_req == act_mode_q);
    assign any_illegal_c = |illegal_c;

    // Mode-switch controller.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= ST_RUN;
            act_mode_q <= MODE_RS;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mode_req != act_mode_q) begin
                        state <= ST_SWITCH;
                        busy  <= 1'b1;
                    end
                end
                ST_SWITCH: begin
                    act_mode_q <= mode_req;
                    state      <= ST_RUN;
                    busy       <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of edges with at least one illegal channel.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= any_illegal_c ? CNT_W'(1) : '0;
        end else if (any_illegal_c && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .clk       (clk),
            .nrst      (nrst),
            .upd       (upd_c),
            .mode      (act_mode_q),
            .s         (S[i]),
            .r         (R[i]),
            .clr_err   (clr_err),
            .q         (Q[i]),
            .err       (err[i]),
            .illegal_c (illegal_c[i])
        );
    end

endmodule : multi_ff_bank

// File: tb/tb_multi_ff_bank.sv
// Directed bench for multi_ff_bank: main instance (CNT_W=8) plus a CNT_W=2
// instance sharing the same stimulus for counter saturation.
module tb_multi_ff_bank;

    logic       clk = 1'b0;
    logic       nrst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s_in;
    logic [7:0] r_in;
    logic       clr_err;

    logic [7:0] q, nq, err;
    logic [1:0] act_mode;
    logic       busy;
    logic [7:0] err_cnt;

    logic [7:0] q2, nq2, err2;
    logic [1:0] act_mode2;
    logic       busy2;
    logic [1:0] err_cnt2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    multi_ff_bank #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .nrst(nrst), .en(en), .mode(mode), .S(s_in), .R(r_in),
        .clr_err(clr_err), .Q(q), .nQ(nq), .act_mode(act_mode), .busy(busy),
        .err(err), .err_cnt(err_cnt)
    );

    multi_ff_bank #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .nrst(nrst), .en(en), .mode(mode), .S(s_in), .R(r_in),
        .clr_err(clr_err), .Q(q2), .nQ(nq2), .act_mode(act_mode2), .busy(busy2),
        .err(err2), .err_cnt(err_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge; sample and drive 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst = 1'b0; en = 1'b1; mode = 2'b00;
        s_in = 8'hFF; r_in = 8'hFF; clr_err = 1'b0;
        cyc();
        check("rst_q",       32'(q),        32'h00);
        check("rst_nq",      32'(nq),       32'hFF);
        check("rst_err",     32'(err),      32'h00);
        check("rst_cnt",     32'(err_cnt),  32'h00);
        check("rst_act",     32'(act_mode), 32'h0);
        check("rst_busy",    32'(busy),     32'h0);

        // RS set / reset / illegal
        nrst = 1'b1; s_in = 8'h0F; r_in = 8'h00;
        cyc(); check("rs_set", 32'(q), 32'h0F);
        check("rs_nq",  32'(nq), 32'hF0);
        s_in = 8'h00; r_in = 8'h03;
        cyc(); check("rs_clr", 32'(q), 32'h0C);
        s_in = 8'h80; r_in = 8'h80;
        cyc(); check("rs_ill_q",   32'(q),       32'h0C);
        check("rs_ill_err", 32'(err),     32'h80);
        check("rs_ill_cnt", 32'(err_cnt), 32'h01);

        // Switch to JK; Q frozen through the switch
        s_in = 8'h00; r_in = 8'h00; mode = 2'b01;
        cyc(); check("sw_busy1", 32'(busy), 32'h1);
        check("sw_act_old", 32'(act_mode), 32'h0);
        check("sw_q_hold1", 32'(q), 32'h0C);
        s_in = 8'hFF; r_in = 8'hFF;
        cyc(); check("sw_busy0", 32'(busy), 32'h0);
        check("sw_act_new", 32'(act_mode), 32'h1);
        check("sw_q_hold2", 32'(q), 32'h0C);
        cyc(); check("jk_tog1", 32'(q), 32'hF3);
        cyc(); check("jk_tog2", 32'(q), 32'h0C);
        check("jk_no_err", 32'(err),     32'h80);
        check("jk_no_cnt", 32'(err_cnt), 32'h01);

        // en=0 holds
        en = 1'b0;
        cyc(); check("en0_hold", 32'(q), 32'h0C);
        en = 1'b1;

        // D mode
        mode = 2'b10; s_in = 8'hA5; r_in = 8'h00;
        cyc(); cyc(); check("d_act", 32'(act_mode), 32'h2);
        check("d_hold", 32'(q), 32'h0C);
        cyc(); check("d_load", 32'(q), 32'hA5);

        // T mode
        mode = 2'b11;
        cyc(); cyc(); check("t_hold", 32'(q), 32'hA5);
        s_in = 8'h0F;
        cyc(); check("t_tog", 32'(q), 32'hAA);

        // Back to RS; clr_err coincident with illegal on channel 2
        mode = 2'b00; s_in = 8'h00; r_in = 8'h00;
        cyc(); cyc(); check("rs_back_act", 32'(act_mode), 32'h0);
        s_in = 8'h04; r_in = 8'h04; clr_err = 1'b1;
        cyc(); check("clr_ill_err", 32'(err),     32'h04);
        check("clr_ill_cnt", 32'(err_cnt), 32'h01);
        check("clr_ill_q",   32'(q),       32'hAA);
        clr_err = 1'b0; s_in = 8'h30; r_in = 8'h30;
        cyc(); check("multi_ill_cnt", 32'(err_cnt), 32'h02);
        check("multi_ill_err", 32'(err), 32'h34);

        // Saturation with CNT_W=2
        nrst = 1'b0;
        cyc(); check("sat_rst", 32'(err_cnt2), 32'h0);
        nrst = 1'b1; s_in = 8'h01; r_in = 8'h01;
        cyc(); check("sat_1", 32'(err_cnt2), 32'h1);
        cyc(); check("sat_2", 32'(err_cnt2), 32'h2);
        cyc(); check("sat_3", 32'(err_cnt2), 32'h3);
        cyc(); check("sat_hold", 32'(err_cnt2), 32'h3);
        check("nosat_4", 32'(err_cnt), 32'h04);

        // Reset in the middle of a switch
        s_in = 8'hFF; r_in = 8'h00;
        cyc(); check("pre_q", 32'(q), 32'hFF);
        mode = 2'b11;
        cyc(); check("mid_busy", 32'(busy), 32'h1);
        nrst = 1'b0;
        cyc(); check("abort_act",  32'(act_mode), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_q",    32'(q),    32'h00);
        nrst = 1'b1;
        cyc(); check("post_rst_sw", 32'(busy), 32'h1);
        check("post_rst_q", 32'(q), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_multi_ff_bank
